hazard_stall_controller: RTL

- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB) that has no forwarding.
- Detects RAW hazards between the instruction in ID and older producers in EX/MEM/WB, and holds PC and IF/ID for exactly the required number of cycles while injecting bubbles into ID/EX.
- Squashes wrong-path instructions when a branch, jump or jr redirect resolves in MEM.
- Keeps saturating performance counters for cycles, stalls and flushes.

---
 rtl/hazard_stall_controller_if.sv | 34 +++
 rtl/hazard_stall_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller_if.sv
// Hazard/redirect bundle between the pipeline datapath and the stall controller.
// The pipeline drives producer/consumer info; the controller drives hold/flush.
interface hazard_stall_controller_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRs;
    logic       ID_UsesRt;
    logic [4:0] EX_Dest;
    logic       EX_RegWrite;
    logic [4:0] MEM_Dest;
    logic       MEM_RegWrite;
    logic [4:0] WB_Dest;
    logic       WB_RegWrite;
    logic       MEM_Redirect;
    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       EXMEM_Flush;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
        output EX_Dest, EX_RegWrite, MEM_Dest, MEM_RegWrite,
        output WB_Dest, WB_RegWrite, MEM_Redirect,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
        input  EX_Dest, EX_RegWrite, MEM_Dest, MEM_RegWrite,
        input  WB_Dest, WB_RegWrite, MEM_Redirect,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// RAW stall / redirect squash sequencer for a 5-stage pipeline without forwarding,
// with saturating cycle, stall and flush counters.
module hazard_stall_controller #(
    parameter int CNT_W          = 32,
    parameter bit RF_WRITE_FIRST = 1'b0
) (
    input  logic                   Clk,
    input  logic                   Rst,
    hazard_stall_controller_if.slave hz,
    output logic [CNT_W-1:0]       CycleCount,
    output logic [CNT_W-1:0]       StallCount,
    output logic [CNT_W-1:0]       FlushCount
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] ExLat  = RF_WRITE_FIRST ? 2'd2 : 2'd3;
    localparam logic [1:0] MemLat = RF_WRITE_FIRST ? 2'd1 : 2'd2;
    localparam logic [1:0] WbLat  = RF_WRITE_FIRST ? 2'd0 : 2'd1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_t     state;
    logic [1:0] rem;
    logic [1:0] need;
    logic       redirect;
    logic       stallNow;

    function automatic logic srcHit(
        input logic       uses,
        input logic [4:0] src,
        input logic       wr,
        input logic [4:0] dst
    );
        return uses && (src != 5'd0) && wr && (src == dst);
    endfunction

    function automatic logic stageHit(input logic wr, input logic [4:0] dst);
        return srcHit(hz.ID_UsesRs, hz.ID_Rs, wr, dst) ||
               srcHit(hz.ID_UsesRt, hz.ID_Rt, wr, dst);
    endfunction

    // Older stages need fewer cycles, so checking youngest last yields the max.
    always_comb begin
        need = 2'd0;
        if (stageHit(hz.WB_RegWrite, hz.WB_Dest))
            need = WbLat;
        if (stageHit(hz.MEM_RegWrite, hz.MEM_Dest))
            need = MemLat;
        if (stageHit(hz.EX_RegWrite, hz.EX_Dest))
            need = ExLat;
    end

    assign redirect = !Rst && hz.MEM_Redirect;
    assign stallNow = !Rst && !hz.MEM_Redirect &&
                      ((state == STALL) || (need != 2'd0));

    always_comb begin
        hz.PCWrite     = 1'b1;
        hz.IFID_Write  = 1'b1;
        hz.IFID_Flush  = 1'b0;
        hz.IDEX_Flush  = 1'b0;
        hz.EXMEM_Flush = 1'b0;
        unique case (1'b1)
            redirect: begin
                hz.IFID_Flush  = 1'b1;
                hz.IDEX_Flush  = 1'b1;
                hz.EXMEM_Flush = 1'b1;
            end
            stallNow: begin
                hz.PCWrite    = 1'b0;
                hz.IFID_Write = 1'b0;
                hz.IDEX_Flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= RUN;
            rem        <= 2'd0;
            CycleCount <= '0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (CycleCount != CntMax)
                CycleCount <= CycleCount + 1'b1;
            if (stallNow && (StallCount != CntMax))
                StallCount <= StallCount + 1'b1;
            if (redirect && (FlushCount != CntMax))
                FlushCount <= FlushCount + 1'b1;

            // A redirect squashes the stalled consumer, so any pending count dies.
            if (redirect) begin
                state <= RUN;
                rem   <= 2'd0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (need > 2'd1) begin
                            state <= STALL;
                            rem   <= need - 2'd1;
                        end
                    end
                    STALL: begin
                        if (rem == 2'd1) begin
                            state <= RUN;
                            rem   <= 2'd0;
                        end else begin
                            rem <= rem - 2'd1;
                        end
                    end
                    default: begin
                        state <= RUN;
                        rem   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
